// File: rtl/calc_pkg.sv
// Shared types and default sizing for the inference calculation sequencer.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    STORE,
    DONE
  } state_t;

  localparam int DEF_NUM_INPUTS  = 784;
  localparam int DEF_NUM_OUTPUTS = 10;
  localparam int DEF_ADDR_W      = 11;
  localparam int DEF_OUT_ADDR_W  = 4;
  localparam int DEF_RES_W       = 17;

endpackage

// File: rtl/calc_sequencer_flex_counter.sv
// Up-counter with synchronous clear that stops at rollover_val instead of wrapping.
module flex_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count_out,
  output logic         rollover_flag
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable && (count_q != rollover_val)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/calc_sequencer.sv
// Walks every output neuron: streams input indices to the SRAMs, times the MAC, stores results.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int OUT_ADDR_W  = DEF_OUT_ADDR_W,
  parameter int RES_W       = DEF_RES_W
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start_calc,
  input  logic [RES_W-1:0]      mac_result,
  output logic [ADDR_W-1:0]     pixel_address,
  output logic [ADDR_W-1:0]     weight_address,
  output logic [OUT_ADDR_W-1:0] weight_bank,
  output logic                  mem_read_en,
  output logic                  mac_clear,
  output logic                  mac_enable,
  output logic                  result_wen,
  output logic [OUT_ADDR_W-1:0] output_address,
  output logic [RES_W-1:0]      result_data,
  output logic                  busy,
  output logic                  done_calc
);

  if (NUM_INPUTS < 1 || NUM_INPUTS > (1 << ADDR_W)) begin : g_bad_inputs
    $error("calc_sequencer: NUM_INPUTS does not fit in ADDR_W");
  end
  if (NUM_OUTPUTS < 1 || NUM_OUTPUTS > (1 << OUT_ADDR_W)) begin : g_bad_outputs
    $error("calc_sequencer: NUM_OUTPUTS does not fit in OUT_ADDR_W");
  end

  localparam logic [ADDR_W-1:0]     IN_LAST  = ADDR_W'(NUM_INPUTS - 1);
  localparam logic [OUT_ADDR_W-1:0] OUT_LAST = OUT_ADDR_W'(NUM_OUTPUTS - 1);

  state_t state_q, state_d;
  logic   mem_read_en_q, mem_read_en_d;
  logic   mac_clear_q, mac_clear_d;
  logic   mac_enable_q, mac_enable_d;
  logic   result_wen_q, result_wen_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic                  in_clear, in_en, in_last;
  logic                  out_clear, out_en, out_last;
  logic [ADDR_W-1:0]     in_idx;
  logic [OUT_ADDR_W-1:0] out_idx;

  flex_counter #(.W(ADDR_W)) u_in_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (in_clear),
    .count_enable (in_en),
    .rollover_val (IN_LAST),
    .count_out    (in_idx),
    .rollover_flag(in_last)
  );

  flex_counter #(.W(OUT_ADDR_W)) u_out_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (out_clear),
    .count_enable (out_en),
    .rollover_val (OUT_LAST),
    .count_out    (out_idx),
    .rollover_flag(out_last)
  );

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    in_clear  = 1'b0;
    in_en     = 1'b0;
    out_clear = 1'b0;
    out_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_calc) begin
          state_d   = CLEAR;
          out_clear = 1'b1;
          done_d    = 1'b0;
        end
      end
      CLEAR: begin
        in_clear = 1'b1;
        state_d  = STREAM;
      end
      STREAM: begin
        in_en = 1'b1;
        if (in_last) state_d = DRAIN;
      end
      DRAIN: state_d = STORE;
      STORE: begin
        if (out_last) begin
          state_d = DONE;
        end else begin
          out_en  = 1'b1;
          state_d = CLEAR;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered so they line up with the state being entered.
    mac_clear_d   = (state_d == CLEAR);
    mem_read_en_d = (state_d == STREAM);
    result_wen_d  = (state_d == STORE);
    busy_d        = (state_d != IDLE);
    mac_enable_d  = mem_read_en_q;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      mem_read_en_q <= 1'b0;
      mac_clear_q   <= 1'b0;
      mac_enable_q  <= 1'b0;
      result_wen_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_read_en_q <= mem_read_en_d;
      mac_clear_q   <= mac_clear_d;
      mac_enable_q  <= mac_enable_d;
      result_wen_q  <= result_wen_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign pixel_address  = in_idx;
  assign weight_address = in_idx;
  assign weight_bank    = out_idx;
  assign output_address = out_idx;
  assign mem_read_en    = mem_read_en_q;
  assign mac_clear      = mac_clear_q;
  assign mac_enable     = mac_enable_q;
  assign result_wen     = result_wen_q;
  assign busy           = busy_q;
  assign done_calc      = done_q;
  // mac_result is only valid during STORE, so it is passed through rather than registered.
  assign result_data    = result_wen_q ? mac_result : '0;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench: a 4x2 instance for cycle-exact checks and a 784x10 instance for full-size timing.
module tb_calc_sequencer;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic        start_s, start_f;
  logic [16:0] mac_s, mac_f;
  logic [10:0] pa_s, wa_s, pa_f, wa_f;
  logic [3:0]  wb_s, oa_s, wb_f, oa_f;
  logic        rd_s, clr_s, en_s, wen_s, busy_s, done_s;
  logic        rd_f, clr_f, en_f, wen_f, busy_f, done_f;
  logic [16:0] rdat_s, rdat_f;

  int n_tests = 0;
  int n_fail  = 0;

  calc_sequencer #(.NUM_INPUTS(4), .NUM_OUTPUTS(2)) u_small (
    .clk(clk), .n_rst(n_rst), .start_calc(start_s), .mac_result(mac_s),
    .pixel_address(pa_s), .weight_address(wa_s), .weight_bank(wb_s),
    .mem_read_en(rd_s), .mac_clear(clr_s), .mac_enable(en_s), .result_wen(wen_s),
    .output_address(oa_s), .result_data(rdat_s), .busy(busy_s), .done_calc(done_s)
  );

  calc_sequencer u_full (
    .clk(clk), .n_rst(n_rst), .start_calc(start_f), .mac_result(mac_f),
    .pixel_address(pa_f), .weight_address(wa_f), .weight_bank(wb_f),
    .mem_read_en(rd_f), .mac_clear(clr_f), .mac_enable(en_f), .result_wen(wen_f),
    .output_address(oa_f), .result_data(rdat_f), .busy(busy_f), .done_calc(done_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, done, mac_clear, mem_read_en, mac_enable, result_wen} for cycle k after start is sampled
  function automatic logic [5:0] exp_ctl(input int k);
    case (k)
      1, 8:                   return 6'b101000;
      2, 9:                   return 6'b100100;
      3, 4, 5, 10, 11, 12:    return 6'b100110;
      6, 13:                  return 6'b100010;
      7, 14:                  return 6'b100001;
      15:                     return 6'b100000;
      default:                return 6'b010000;
    endcase
  endfunction

  function automatic logic [5:0] ctl_s();
    return {busy_s, done_s, clr_s, rd_s, en_s, wen_s};
  endfunction

  task automatic check_small_cycle(input int k);
    chk($sformatf("s_ctl_c%0d", k), 32'(ctl_s()), 32'(exp_ctl(k)));
    if (k >= 2 && k <= 5) begin
      chk("s_addr_n0", 32'(pa_s), k - 2);
      chk("s_waddr_n0", 32'(wa_s), k - 2);
      chk("s_bank_n0", 32'(wb_s), 0);
    end
    if (k >= 9 && k <= 12) begin
      chk("s_addr_n1", 32'(pa_s), k - 9);
      chk("s_waddr_n1", 32'(wa_s), k - 9);
      chk("s_bank_n1", 32'(wb_s), 1);
    end
    if (k == 7) begin
      chk("s_oa0", 32'(oa_s), 0);
      chk("s_data0", 32'(rdat_s), 5);
    end
    if (k == 14) begin
      chk("s_oa1", 32'(oa_s), 1);
      chk("s_data1", 32'(rdat_s), 9);
    end
  endtask

  // One full small run; a start pulse is injected at cycle pulse_k (0 = none).
  task automatic run_small(input int pulse_k);
    mac_s   = 17'd5;
    start_s = 1'b1;
    tick();
    for (int k = 1; k <= 15; k++) begin
      start_s = (k == pulse_k);
      if (k == 8) mac_s = 17'd9;
      check_small_cycle(k);
      tick();
    end
    start_s = 1'b0;
    chk("s_ctl_after_done", 32'(ctl_s()), 32'(exp_ctl(16)));
  endtask

  initial begin
    int c, nw, maxa, maxb, minb, weq;
    n_rst = 1'b0; start_s = 1'b0; start_f = 1'b0;
    mac_s = '0; mac_f = '0;
    tick(); tick();
    chk("rst_ctl_s", 32'(ctl_s()), 0);
    chk("rst_addr_s", 32'({pa_s, wa_s, wb_s, oa_s}), 0);
    chk("rst_data_s", 32'(rdat_s), 0);
    chk("rst_ctl_f", 32'({busy_f, done_f, clr_f, rd_f, en_f, wen_f}), 0);
    chk("rst_addr_f", 32'({pa_f, wa_f, wb_f, oa_f}), 0);
    n_rst = 1'b1;
    tick();
    chk("idle_ctl", 32'(ctl_s()), 0);

    run_small(0);
    run_small(4);
    tick();
    chk("idle_done_hold", 32'(ctl_s()), 32'b010000);

    // reset during neuron 1 STREAM
    mac_s = 17'd5; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    chk("mid_in_stream", 32'({rd_s, wb_s}), 32'h11);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("mid_rst_ctl", 32'(ctl_s()), 0);
    chk("mid_rst_addr", 32'({pa_s, wa_s, wb_s, oa_s}), 0);
    chk("mid_rst_data", 32'(rdat_s), 0);
    for (int k = 0; k < 20; k++) begin
      chk("mid_after", 32'({busy_s, wen_s, done_s}), 0);
      tick();
    end

    // full-size run
    mac_f = 17'h1ABCD; start_f = 1'b1;
    tick();
    start_f = 1'b0;
    c = 0; nw = 0; maxa = 0; maxb = 0; minb = 15; weq = 1;
    while (c < 9000 && !done_f) begin
      if (wen_f) begin
        chk("f_oa", 32'(oa_f), nw);
        chk("f_data", 32'(rdat_f), 32'h1ABCD);
        nw++;
      end
      if (rd_f) begin
        if (int'(pa_f) > maxa) maxa = int'(pa_f);
        if (int'(wb_f) > maxb) maxb = int'(wb_f);
        if (int'(wb_f) < minb) minb = int'(wb_f);
        if (wa_f != pa_f) weq = 0;
      end
      tick();
      c++;
    end
    chk("f_done_cyc", c, 7871);
    chk("f_wen_cnt", nw, 10);
    chk("f_max_addr", maxa, 783);
    chk("f_max_bank", maxb, 9);
    chk("f_min_bank", minb, 0);
    chk("f_waddr_eq", weq, 1);
    chk("f_busy_end", 32'(busy_f), 0);

    // start held high: one idle cycle between DONE and the next CLEAR
    mac_s = 17'd5; start_s = 1'b1;
    tick();
    for (int k = 1; k <= 17; k++) begin
      if (k == 8) mac_s = 17'd9;
      if (k == 17) begin
        mac_s = 17'd5;
        chk("held_relaunch", 32'(ctl_s()), 32'b101000);
      end else begin
        check_small_cycle(k);
      end
      tick();
    end
    start_s = 1'b0;
    c = 0;
    while (c < 40 && !done_s) begin
      tick();
      c++;
    end
    chk("held_second_done", c, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
